mac_dot_sequencer: RTL and testbench
====================================

// Module: mac_dot_sequencer
// PURPOSE
//  Feeds the 32x32 MAC unit upstream: buffers operand pairs in a small FIFO and
//  runs a dot product of vec_len pairs through the MAC.
//  It clears the MAC accumulator, drives one pair per cycle (zeros when starved),
//  then captures the 65-bit accumulator into a result register with a one-cycle valid pulse.
// PARAMETERS
//  DEPTH  4   operand FIFO entries (power of two, >=2)
//  LEN_W  16  width of vec_len; max job length 2^LEN_W-1 pairs
// PORTS
//  clk               in   1      system clock, rising edge
//  reset             in   1      asynchronous, active-low (0 = reset)
//  start             in   1      begin job; sampled only in IDLE
//  vec_len           in   LEN_W  pairs in job; sampled with start
//  in_valid          in   1      operand pair valid
//  in_ready          out  1      FIFO can accept; push = in_valid & in_ready
//  in_a              in   32     operand A (to MAC multiplicand)
//  in_b              in   32     operand B (to MAC multiplier)
//  mac_multiplicand  out  32     registered operand to MAC
//  mac_multiplier    out  32     registered operand to MAC
//  mac_clear         out  1      registered; drives MAC sync active-high reset
//  mac_acc           in   65     MAC accumulator_out
//  result            out  65     captured dot product; holds until next capture
//  result_valid      out  1      one-cycle pulse when result updates
//  busy              out  1      high in any state other than IDLE
// BEHAVIOUR
//  Reset values: operands 0, mac_clear 1, result 0, result_valid 0, busy 0.
//  Reset also empties the FIFO and sets the state to IDLE.
//  mac_clear=1 throughout reset, so the MAC clears on every edge during reset.
//  FIFO: in_ready = !full in every state, so pairs may be prefetched in IDLE. There is no bypass.
//  A push into an empty FIFO is poppable on the following edge. Push and pop on the same edge are both honoured.
//  Operands are registered. Any edge that does not pop loads operands with 0, so the MAC adds 0.
//  FSM (all transitions on the rising clk edge):
//   IDLE:    mac_clear<=0. If start: latch vec_len into remaining, mac_clear<=1, go CLEAR. Otherwise stay.
//   CLEAR:   the MAC clears at this edge; mac_clear<=0. Go to WAIT if remaining==0, otherwise go to STREAM.
//   STREAM:  if FIFO non-empty: pop, operands<=head, remaining--. Otherwise operands<=0.
//            The edge that pops the last pair (remaining 1->0) moves to WAIT.
//   WAIT:    the MAC adds the last pair at this edge; operands<=0; go CAPTURE.
//   CAPTURE: result<=mac_acc, result_valid<=1, go IDLE.
//  start is ignored when busy. vec_len is ignored except when start is accepted.
//  Latency: with no starvation, result_valid is high exactly vec_len+4 cycles after the start cycle.
//   Example: start in cycle 0, vec_len=N -> result_valid in cycle N+4.
//   Each starved STREAM cycle adds 1 cycle.
//  Arithmetic: none internal. The result equals the MAC's 65-bit sum, modulo 2^65.
//  Reset mid-job aborts immediately. No result_valid is produced. Unpopped FIFO data is lost.
// TESTING
//  Prefill (1,2),(3,4),(5,6),(7,8); start, vec_len=4 -> result=100; result_valid in cycle 8 only.
//  vec_len=0 -> no pops; result=0; result_valid in cycle 4; FIFO contents untouched.
//  vec_len=3; one pair every 3rd cycle, (2,5),(4,5),(6,5) -> result=60.
//   Operands are 0 in the gap cycles; result_valid is 6 cycles later than in the unstarved case.
//  DEPTH=4: push 5 pairs in IDLE -> in_ready low after 4 pushes.
//   The 5th pair is held by the source and accepted after the first pop; no pair is lost or duplicated.
//  Two pairs (FFFFFFFF,FFFFFFFF) -> result=65'h1_FFFF_FFFC_0000_0002.
//  Reset asserted in STREAM -> all outputs at reset values immediately and FIFO empty.
//   After release, a new 2-pair job (3,3),(4,4) -> result=25.
//  start pulsed during busy -> ignored; the job in progress completes unchanged.

Source files
------------

// File: rtl/mac_dot_sequencer.sv
// Operand-pair FIFO plus sequencer that streams a vec_len-pair dot product through an external 32x32 MAC.
// Result pulses vec_len+4 cycles after start (+1 per starved cycle); in_ready is FIFO-not-full in every state.

module mac_dot_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_vld,
   output logic         push_rdy,
   input  logic [W-1:0] push_dat,
   output logic         pop_vld,
   input  logic         pop_rdy,
   output logic [W-1:0] pop_dat
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic         do_push, do_pop;

   // Pointers carry one wrap bit so full and empty are distinguishable.
   assign push_rdy = !((wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]));
   assign pop_vld  = (wptr_q != rptr_q);
   assign pop_dat  = mem_q[rptr_q[AW-1:0]];
   assign do_push  = push_vld && push_rdy;
   assign do_pop   = pop_rdy && pop_vld;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (do_push) wptr_d = wptr_q + PTR_ONE;
      if (do_pop)  rptr_d = rptr_q + PTR_ONE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= push_dat;
   end
endmodule

module mac_dot_sequencer #(
   parameter int DEPTH = 4,
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [LEN_W-1:0] vec_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   output logic [31:0]      mac_multiplicand,
   output logic [31:0]      mac_multiplier,
   output logic             mac_clear,
   input  logic [64:0]      mac_acc,
   output logic [64:0]      result,
   output logic             result_valid,
   output logic             busy
);
   localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_STREAM, S_WAIT, S_CAPTURE} state_t;
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
   } pair_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] remaining_q, remaining_d;
   logic [31:0]      opa_q, opa_d, opb_q, opb_d;
   logic             mac_clear_q, mac_clear_d;
   logic [64:0]      result_q, result_d;
   logic             result_valid_q, result_valid_d;
   pair_t            in_pair, head;
   logic             head_vld, pop;

   assign in_pair = '{a: in_a, b: in_b};
   assign pop     = (state_q == S_STREAM) && head_vld;

   mac_dot_fifo #(.W($bits(pair_t)), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push_vld (in_valid),
      .push_rdy (in_ready),
      .push_dat (in_pair),
      .pop_vld  (head_vld),
      .pop_rdy  (pop),
      .pop_dat  (head)
   );

   // Operands default to zero so any non-popping edge makes the MAC add nothing.
   always_comb begin
      state_d        = state_q;
      remaining_d    = remaining_q;
      opa_d          = '0;
      opb_d          = '0;
      mac_clear_d    = 1'b0;
      result_d       = result_q;
      result_valid_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               remaining_d = vec_len;
               mac_clear_d = 1'b1;
               state_d     = S_CLEAR;
            end
         end
         S_CLEAR:  state_d = (remaining_q == '0) ? S_WAIT : S_STREAM;
         S_STREAM: begin
            if (head_vld) begin
               opa_d       = head.a;
               opb_d       = head.b;
               remaining_d = remaining_q - LEN_ONE;
               if (remaining_q == LEN_ONE) state_d = S_WAIT;
            end
         end
         S_WAIT:   state_d = S_CAPTURE;
         S_CAPTURE: begin
            result_d       = mac_acc;
            result_valid_d = 1'b1;
            state_d        = S_IDLE;
         end
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= S_IDLE;
         remaining_q    <= '0;
         opa_q          <= '0;
         opb_q          <= '0;
         mac_clear_q    <= 1'b1;
         result_q       <= '0;
         result_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         remaining_q    <= remaining_d;
         opa_q          <= opa_d;
         opb_q          <= opb_d;
         mac_clear_q    <= mac_clear_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
      end
   end

   assign mac_multiplicand = opa_q;
   assign mac_multiplier   = opb_q;
   assign mac_clear        = mac_clear_q;
   assign result           = result_q;
   assign result_valid     = result_valid_q;
   assign busy             = (state_q != S_IDLE);
endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Scoreboard bench for mac_dot_sequencer with a behavioural MAC and a pair/job-level reference model.

module tb_mac_dot_sequencer;
   localparam int DEPTH = 4;
   localparam int LEN_W = 16;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic [LEN_W-1:0] vec_len = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      in_a = '0, in_b = '0;
   logic [31:0]      mac_multiplicand, mac_multiplier;
   logic             mac_clear;
   logic [64:0]      mac_acc;
   logic [64:0]      result;
   logic             result_valid;
   logic             busy;

   always #5 clk = ~clk;

   mac_dot_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .vec_len          (vec_len),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_a             (in_a),
      .in_b             (in_b),
      .mac_multiplicand (mac_multiplicand),
      .mac_multiplier   (mac_multiplier),
      .mac_clear        (mac_clear),
      .mac_acc          (mac_acc),
      .result           (result),
      .result_valid     (result_valid),
      .busy             (busy)
   );

   // External MAC: synchronous active-high clear, otherwise accumulate the product every edge.
   always @(posedge clk) begin
      if (mac_clear) mac_acc <= '0;
      else           mac_acc <= mac_acc + 65'(mac_multiplicand) * 65'(mac_multiplier);
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      int          c;
   } push_t;
   typedef struct {
      int len;
      int s;
   } job_t;
   typedef struct {
      logic [64:0] res;
      int          vcyc;
   } exp_t;

   push_t pair_q[$];
   job_t  job_q[$];
   exp_t  exp_q[$];
   int    checks = 0;
   int    failures = 0;

   function automatic void check(input string name, input logic [64:0] act, input logic [64:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // A job takes the next len accepted pairs in order. Pair i is popped in the first cycle that is
   // at least start+2, after the previous pop, and after the cycle it was accepted in.
   function automatic void resolve();
      job_t        j;
      push_t       e;
      logic [64:0] sum;
      int          p;
      int          v;
      while (job_q.size() > 0 && pair_q.size() >= job_q[0].len) begin
         j   = job_q.pop_front();
         sum = '0;
         p   = j.s + 1;
         for (int i = 0; i < j.len; i++) begin
            e   = pair_q.pop_front();
            sum = sum + 65'(e.a) * 65'(e.b);
            p   = (p + 1 > e.c + 1) ? p + 1 : e.c + 1;
         end
         v = (j.len == 0) ? j.s + 4 : p + 3;
         exp_q.push_back('{sum, v});
      end
   endfunction

   // Called at a negedge; in_ready is stable there and decides acceptance at the next posedge.
   task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         checks++;
         failures++;
         $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles, required 1", t);
      end else begin
         pair_q.push_back('{a, b, cyc});
         resolve();
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic start_job(input int n, input bit accepted);
      start   = 1'b1;
      vec_len = LEN_W'(n);
      if (accepted) begin
         job_q.push_back('{n, cyc});
         resolve();
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((busy || exp_q.size() > 0) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (t >= 2000) begin
         failures++;
         $display("FAIL job_timeout: busy=%0d pending=%0d after %0d cycles, required idle", busy, exp_q.size(), t);
      end
   endtask

   // Monitor: every result_valid must match the oldest expected result, value and cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset && result_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_valid: result_valid=1 result=%0h, required no pulse", result);
            end else begin
               e = exp_q.pop_front();
               check("result_value", result, e.res);
               check("result_cycle", 65'(cyc), 65'(e.vcyc));
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check("rst_multiplicand", 65'(mac_multiplicand), 65'd0);
      check("rst_multiplier", 65'(mac_multiplier), 65'd0);
      check("rst_mac_clear", 65'(mac_clear), 65'd1);
      check("rst_result", result, 65'd0);
      check("rst_result_valid", 65'(result_valid), 65'd0);
      check("rst_busy", 65'(busy), 65'd0);
      check("rst_in_ready", 65'(in_ready), 65'd1);
      reset = 1'b1;
      @(negedge clk);
      check("idle_mac_clear", 65'(mac_clear), 65'd0);

      // Prefilled 4-pair job.
      push_pair(1, 2); push_pair(3, 4); push_pair(5, 6); push_pair(7, 8);
      start_job(4, 1'b1);
      wait_idle();
      check("t1_result", result, 65'd100);

      // Zero-length job leaves FIFO contents for the next job.
      push_pair(9, 10); push_pair(11, 12);
      start_job(0, 1'b1);
      wait_idle();
      check("len0_result", result, 65'd0);
      start_job(2, 1'b1);
      wait_idle();
      check("after_len0_result", result, 65'd222);

      // Starved job: one pair every third cycle.
      fork
         start_job(3, 1'b1);
         begin
            repeat (3) @(negedge clk);
            push_pair(2, 5);
            repeat (2) @(negedge clk);
            push_pair(4, 5);
            repeat (2) @(negedge clk);
            push_pair(6, 5);
         end
      join
      wait_idle();
      check("starved_result", result, 65'd60);

      // FIFO full in IDLE; fifth pair waits for the first pop.
      push_pair(1, 1); push_pair(2, 2); push_pair(3, 3); push_pair(4, 4);
      check("full_in_ready", 65'(in_ready), 65'd0);
      fork
         push_pair(5, 5);
         start_job(5, 1'b1);
      join
      wait_idle();
      check("full_result", result, 65'd55);

      // Maximum operands.
      push_pair(32'hFFFF_FFFF, 32'hFFFF_FFFF); push_pair(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      start_job(2, 1'b1);
      wait_idle();
      check("max_result", result, 65'h1_FFFF_FFFC_0000_0002);

      // start while busy is ignored.
      push_pair(10, 1); push_pair(20, 1); push_pair(30, 1); push_pair(40, 1);
      start_job(4, 1'b1);
      @(negedge clk);
      start_job(1, 1'b0);
      wait_idle();
      check("busy_start_result", result, 65'd100);
      check("busy_start_in_ready", 65'(in_ready), 65'd1);

      // Reset in STREAM with unpopped data in the FIFO.
      push_pair(8, 8); push_pair(8, 8); push_pair(8, 8); push_pair(8, 8);
      start_job(4, 1'b1);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check("mid_rst_multiplicand", 65'(mac_multiplicand), 65'd0);
      check("mid_rst_multiplier", 65'(mac_multiplier), 65'd0);
      check("mid_rst_mac_clear", 65'(mac_clear), 65'd1);
      check("mid_rst_result", result, 65'd0);
      check("mid_rst_result_valid", 65'(result_valid), 65'd0);
      check("mid_rst_busy", 65'(busy), 65'd0);
      check("mid_rst_in_ready", 65'(in_ready), 65'd1);
      pair_q.delete();
      job_q.delete();
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      push_pair(3, 3); push_pair(4, 4);
      start_job(2, 1'b1);
      wait_idle();
      check("post_rst_result", result, 65'd25);

      // Randomized jobs with random source gaps.
      for (int j = 0; j < 8; j++) begin
         n = $urandom_range(1, 8);
         fork
            begin
               repeat ($urandom_range(0, 2)) @(negedge clk);
               start_job(n, 1'b1);
            end
            begin
               for (int i = 0; i < n; i++) begin
                  repeat ($urandom_range(0, 3)) @(negedge clk);
                  push_pair($urandom, $urandom);
               end
            end
         join
         wait_idle();
      end

      repeat (5) @(negedge clk);
      check("scoreboard_drained", 65'(exp_q.size()), 65'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
